// File: rtl/alu_issue.sv
// Single-issue execute controller feeding the Cpu16 alu: register-file operand read,
// one-cycle ALU drive, registered result capture and writeback every 3 clocks.
`ifndef ALU_OPID_WIDTH
`define ALU_OPID_WIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`endif
`ifndef ALU_OP_ADC
`define ALU_OP_ADC  4'd1
`endif
`ifndef ALU_OP_SUB
`define ALU_OP_SUB  4'd2
`endif
`ifndef ALU_OP_SBC
`define ALU_OP_SBC  4'd3
`endif
`ifndef ALU_OP_TEST
`define ALU_OP_TEST 4'd4
`endif
`ifndef ALU_OP_NOT
`define ALU_OP_NOT  4'd5
`endif
`ifndef ALU_OP_NEG
`define ALU_OP_NEG  4'd6
`endif
`ifndef ALU_OP_SHL
`define ALU_OP_SHL  4'd7
`endif
`ifndef ALU_OP_SHR
`define ALU_OP_SHR  4'd8
`endif
`ifndef ALU_OP_NOP
`define ALU_OP_NOP  4'hF
`endif

module alu_issue #(
  parameter int unsigned BITS    = 16,
  parameter int unsigned REGS    = 16,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [`ALU_OPID_WIDTH-1:0] instr_op,
  input  logic [$clog2(REGS)-1:0]    instr_rd,
  input  logic [$clog2(REGS)-1:0]    instr_rs1,
  input  logic [$clog2(REGS)-1:0]    instr_rs2,
  input  logic [BITS-1:0]            instr_imm,
  input  logic                       instr_use_imm,
  input  logic                       instr_no_wb,
  output logic [`ALU_OPID_WIDTH-1:0] alu_op_id,
  output logic [BITS-1:0]            alu_op1,
  output logic [BITS-1:0]            alu_op2,
  input  logic [BITS-1:0]            alu_out,
  input  logic                       alu_z,
  input  logic                       alu_c,
  output logic                       wb_valid,
  output logic [$clog2(REGS)-1:0]    wb_rd,
  output logic [BITS-1:0]            wb_data,
  output logic                       flag_z,
  output logic                       flag_c,
  input  logic [$clog2(REGS)-1:0]    dbg_addr,
  output logic [BITS-1:0]            dbg_data
);

  localparam int unsigned AW = $clog2(REGS);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [BITS-1:0] r_regs [REGS];
  logic [AW-1:0]   r_rd;
  logic            r_no_wb;
  logic            w_accept;
  logic            w_wb_we;
  logic [BITS-1:0] w_rs1_val;
  logic [BITS-1:0] w_rs2_val;

  // Next-state and strobe decode
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_wb_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_accept     = 1'b1;
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: w_next_state = S_WB;
      S_WB: begin
        w_next_state = S_IDLE;
        w_wb_we      = !r_no_wb && !(R0_ZERO && (r_rd == '0));
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_rs1_val = (R0_ZERO && (instr_rs1 == '0)) ? '0 : r_regs[instr_rs1];
  assign w_rs2_val = (R0_ZERO && (instr_rs2 == '0)) ? '0 : r_regs[instr_rs2];

  // State, ALU drive, handshake and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      instr_ready <= 1'b1;
      wb_valid    <= 1'b0;
      alu_op_id   <= `ALU_OP_NOP;
      alu_op1     <= '0;
      alu_op2     <= '0;
      r_rd        <= '0;
      r_no_wb     <= 1'b0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      instr_ready <= (w_next_state == S_IDLE);
      wb_valid    <= (w_next_state == S_WB);
      if (w_accept) begin
        alu_op_id <= instr_op;
        alu_op1   <= w_rs1_val;
        alu_op2   <= instr_use_imm ? instr_imm : w_rs2_val;
        r_rd      <= instr_rd;
        r_no_wb   <= instr_no_wb;
      end
      // ALU has registered its result by the end of EXEC; park it on NOP
      if (r_state == S_EXEC) begin
        alu_op_id <= `ALU_OP_NOP;
      end
      if (r_state == S_WB) begin
        flag_z <= alu_z;
        flag_c <= alu_c;
      end
    end
  end

  // Register file, written on the edge that ends WB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_we) begin
      r_regs[r_rd] <= alu_out;
    end
  end

  // The ALU result register is the writeback data source
  assign wb_rd    = r_rd;
  assign wb_data  = alu_out;
  assign dbg_data = (R0_ZERO && (dbg_addr == '0)) ? '0 : r_regs[dbg_addr];

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Single-issue execute controller that sits directly upstream of the Cpu16 `alu` and feeds it.
- Accepts one decoded instruction per handshake and reads operands from an internal register file.
- Drives the ALU's op_id/op1/op2 for exactly one clock, captures the registered ALU result and flags one clock later, then writes the result back.
- Serial, non-pipelined: one instruction completes every 3 clocks, so there are no data hazards.

Parameters:
- BITS, 16: datapath width; must match the `alu` instance.
- REGS, 16: register file depth. Register address width is log2(REGS) = 4.
- R0_ZERO, 1: when 1, r0 reads as 0 and writes to r0 are discarded.

Ports:
- clk  in  1  system clock, shared with `alu`.
- reset  in  1  asynchronous, active-high reset.
- instr_valid  in  1  decoded instruction present.
- instr_ready  out  1  block can accept an instruction.
- instr_op  in  `ALU_OPID_WIDTH  ALU operation, using the `ALU_OP_* codes.
- instr_rd  in  4  destination register.
- instr_rs1  in  4  source register for op1.
- instr_rs2  in  4  source register for op2.
- instr_imm  in  BITS  immediate value.
- instr_use_imm  in  1  when 1, op2 = instr_imm instead of reg[rs2].
- instr_no_wb  in  1  when 1, update flags only; no register write (CMP/TST style).
- alu_op_id  out  `ALU_OPID_WIDTH  to alu.op_id.
- alu_op1  out  BITS  to alu.op1.
- alu_op2  out  BITS  to alu.op2.
- alu_out  in  BITS  from alu.out.
- alu_z  in  1  from alu.z.
- alu_c  in  1  from alu.c.
- wb_valid  out  1  high during the writeback cycle.
- wb_rd  out  4  destination register of the current writeback.
- wb_data  out  BITS  equals alu_out during the writeback cycle.
- flag_z  out  1  architectural zero flag.
- flag_c  out  1  architectural carry flag.
- dbg_addr  in  4  debug read address.
- dbg_data  out  BITS  combinational read of reg[dbg_addr]; r0 reads 0 when R0_ZERO=1.

Behaviour:
- FSM states: IDLE, EXEC, WB. All outputs and state are registered unless stated otherwise.
- Reset (async, any state):
  - state = IDLE; instr_ready = 1; wb_valid = 0.
  - flag_z = 0, flag_c = 0.
  - All registers cleared to 0.
  - alu_op_id = `ALU_OP_NOP (the alu.vh encoding outside the nine defined ops; the ALU holds out). alu_op1 = alu_op2 = 0.
  - An in-flight instruction is dropped with no writeback.
- IDLE:
  - instr_ready = 1.
  - On a clock edge with instr_valid=1, latch:
    - alu_op_id <= instr_op
    - alu_op1 <= reg[rs1]
    - alu_op2 <= instr_use_imm ? instr_imm : reg[rs2]
    - rd and no_wb into internal registers.
  - Then go to EXEC. With instr_valid=0, stay in IDLE.
- EXEC:
  - instr_ready = 0. ALU inputs are stable, and the ALU registers its result on the edge that ends EXEC.
  - On that edge: alu_op_id <= `ALU_OP_NOP, state -> WB.
- WB:
  - instr_ready = 0; wb_valid = 1; wb_rd = latched rd; wb_data = alu_out.
  - On the edge that ends WB:
    - flag_z <= alu_z and flag_c <= alu_c.
    - reg[rd] <= alu_out, unless no_wb=1 or (R0_ZERO and rd=0).
    - state -> IDLE.
- Latency: accept edge E0; ALU result registered at E0+1; register and flags written at E0+2. The earliest next accept is at E0+3.
- Operand reads always see completed writebacks, because the read happens after the previous WB edge. No bypass is needed.
- Unary ops (TEST, NOT, NEG, SHL, SHR) ignore op2; it is still driven.
- ADC/SBC use the ALU's internal carry. flag_c mirrors alu_c, and the ALU's c is changed only by ADD/ADC/SUB/SBC.
- instr_valid while instr_ready=0 is ignored. Upstream must hold the instruction until it is accepted.
- An unknown instr_op is passed through. The ALU treats it as NOP, so the writeback writes the ALU's previous out.
- Register writes to index 0 follow R0_ZERO.

Test Plan:
- Reset mid-EXEC after an accepted ADD r1=r0+5 → wb_valid never asserts, r1 stays 0, instr_ready=1 on the next cycle.
- ADD r1=r0+imm 5, then ADD r2=r1+imm 0xFFFB → dbg r1=5, r2=0x0000, flag_z=1, flag_c=1, each instruction 3 clocks accept-to-accept.
- ADC r3=r0+imm 0 right after the carry case above → r3=1, flag_c=0.
- SUB no_wb r1-imm 5 with r1=5 → flag_z=1, flag_c=0, r1 unchanged at 5, wb_valid=1 for one cycle.
- NEG r4=r1 (5) then SHR r5=r4 → r4=0xFFFB, r5=0x7FFD. Write to r0 via TEST r0=r1 → r0 still reads 0.
- instr_valid held high continuously → exactly one accept per 3 clocks; instr_ready low in EXEC and WB. alu_op_id=NOP outside EXEC.
